mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arb_rr_arb2.sv | 31 +++
 rtl/mem_port_arb.sv | 146 ++++++++++++++
 tb/tb_mem_port_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter: FSM encoding,
// access width codes, requester indices and the alignment rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b010;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;

    localparam int REQ_LD = 0;
    localparam int REQ_ST = 1;

    function automatic logic misaligned(input logic [2:0] bhw, input logic [1:0] addr_lo);
        return ((bhw == BHW_W) && (addr_lo != 2'b00)) ||
               (((bhw == BHW_H) || (bhw == BHW_HU)) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_port_arb_rr_arb2.sv
// Two-way round-robin picker: combinational pick plus the last-granted pointer,
// which advances only when a grant is actually issued.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;  // index of the requester granted most recently

    always_comb begin
        grant = 2'b00;
        if (req[REQ_LD] && (!req[REQ_ST] || last))
            grant[REQ_LD] = 1'b1;
        else if (req[REQ_ST])
            grant[REQ_ST] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (advance && (req != 2'b00))
            last <= grant[REQ_ST];
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shared-RAM port arbiter for the load and store queues (IDLE -> BUSY -> DONE).
// Optional alignment check enabled by defining MEM_ARB_MISALIGN_CHK_EN.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int NREQ    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [3*NREQ-1:0]    req_bhw,
    input  logic [32*NREQ-1:0]   req_rs1,
    input  logic [32*NREQ-1:0]   req_rs2,
    input  logic [32*NREQ-1:0]   req_imm,
    output logic [NREQ-1:0]      req_grant,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [2:0]           ram_bhw,
    output logic [31:0]          ram_addr,
    output logic [31:0]          ram_din,
    input  logic [31:0]          ram_dout,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic                 err
);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  bhw_q;
    logic [31:0] addr_q, din_q;
    logic        owner;
    logic [1:0]  pick;
    logic        sel;
    logic [31:0] sel_addr, sel_din;
    logic [2:0]  sel_bhw;
    logic        sel_mis;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (state == ST_IDLE),
        .grant   (pick)
    );

    assign sel      = pick[REQ_ST];
    assign sel_addr = sel ? (req_rs1[32 +: 32] + req_imm[32 +: 32])
                          : (req_rs1[0 +: 32]  + req_imm[0 +: 32]);
    assign sel_din  = sel ? req_rs2[32 +: 32] : req_rs2[0 +: 32];
    assign sel_bhw  = sel ? req_bhw[3 +: 3]   : req_bhw[0 +: 3];

`ifdef MEM_ARB_MISALIGN_CHK_EN
    logic err_q;

    assign sel_mis = misaligned(sel_bhw, sel_addr[1:0]);
    assign err     = (state == ST_DONE) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if ((state == ST_IDLE) && (req_valid != '0))
            err_q <= sel_mis;
    end
`else
    assign sel_mis = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output and next-state variable is defaulted first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_grant = '0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        done      = '0;
        unique case (state)
            ST_IDLE: begin
                if (!rst && (req_valid != '0)) begin
                    req_grant = pick;
                    state_nxt = sel_mis ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                ram_cs = 1'b1;
                ram_we = we_q;
                if (cnt == 4'd0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done[owner] = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are captured on the grant edge and held through BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 4'd0;
            we_q   <= 1'b0;
            bhw_q  <= 3'b000;
            addr_q <= 32'd0;
            din_q  <= 32'd0;
            owner  <= 1'b0;
            rdata  <= 32'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid != '0) begin
                        cnt    <= 4'(LATENCY - 1);
                        we_q   <= req_we[sel];
                        bhw_q  <= sel_bhw;
                        addr_q <= sel_addr;
                        din_q  <= sel_din;
                        owner  <= sel;
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        if (!we_q)
                            rdata <= ram_dout;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_bhw  = bhw_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: a timeline model of each access checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arb;

    localparam int          L        = 2;
    localparam logic [31:0] RAM_MASK = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [5:0]  req_bhw = '0;
    logic [63:0] req_rs1 = '0, req_rs2 = '0, req_imm = '0;
    logic [1:0]  req_grant, done;
    logic        ram_cs, ram_we, err;
    logic [2:0]  ram_bhw;
    logic [31:0] ram_addr, ram_din, ram_dout, rdata;

    mem_port_arb #(.LATENCY(L), .NREQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_bhw   (req_bhw),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .req_grant (req_grant),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_bhw   (ram_bhw),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .done      (done),
        .rdata     (rdata),
        .err       (err)
    );

    // RAM stand-in: read data is a fixed function of the address.
    assign ram_dout = ram_addr ^ RAM_MASK;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic mis_rule(input logic [2:0] bhw, input logic [31:0] a);
`ifdef MEM_ARB_MISALIGN_CHK_EN
        return ((bhw == 3'b010) && (a[1:0] != 2'b00)) || ((bhw[1:0] == 2'b01) && a[0]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int winner(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return last ? 0 : 1;
    endfunction

    // Model: an access granted in cycle g drives the RAM in g+1..g+L and completes in g+L+1
    // (a misaligned one completes in g+1 without touching the RAM).
    logic        m_active = 1'b0;
    logic        m_last   = 1'b1;
    int          m_g, m_w;
    logic        m_we, m_mis;
    logic [2:0]  m_bhw;
    logic [31:0] m_addr, m_din;
    logic [31:0] m_rdata  = '0;

    always @(negedge clk) begin : compare
        logic [1:0] g_exp, d_exp;
        logic       cs_exp, we_exp, err_exp, finish;
        int         d, w;
        g_exp = '0; d_exp = '0; cs_exp = 0; we_exp = 0; err_exp = 0; finish = 0;
        if (rst) begin
            m_active = 0;
            m_last   = 1;
            m_rdata  = '0;
            check("rst_ctl", {req_grant, ram_cs, ram_we, done, err, ram_bhw}, '0);
            check("rst_addr", ram_addr, '0);
            check("rst_din", ram_din, '0);
            check("rst_rdata", rdata, '0);
        end else begin
            if (m_active) begin
                d = cyc - m_g;
                if (m_mis) begin
                    if (d == 1) begin d_exp[m_w] = 1'b1; err_exp = 1'b1; finish = 1; end
                end else if (d <= L) begin
                    cs_exp = 1'b1;
                    we_exp = m_we;
                end else begin
                    d_exp[m_w] = 1'b1;
                    finish     = 1;
                    if (!m_we) m_rdata = m_addr ^ RAM_MASK;
                end
            end else if (req_valid != 2'b00) begin
                w          = winner(req_valid, m_last);
                g_exp[w]   = 1'b1;
                m_last     = (w == 1);
                m_w        = w;
                m_g        = cyc;
                m_active   = 1;
                m_we       = req_we[w];
                m_bhw      = req_bhw[3*w +: 3];
                m_addr     = req_rs1[32*w +: 32] + req_imm[32*w +: 32];
                m_din      = req_rs2[32*w +: 32];
                m_mis      = mis_rule(m_bhw, m_addr);
            end
            check("grant", req_grant, g_exp);
            check("ram_cs", ram_cs, cs_exp);
            check("ram_we", ram_we, we_exp);
            check("done", done, d_exp);
            check("err", err, err_exp);
            check("rdata", rdata, m_rdata);
            if (cs_exp) begin
                check("ram_addr", ram_addr, m_addr);
                check("ram_din", ram_din, m_din);
                check("ram_bhw", ram_bhw, m_bhw);
            end
            if (finish) m_active = 0;
        end
    end

    task automatic set_req(input int i, input logic we, input logic [2:0] bhw,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        req_we[i]          = we;
        req_bhw[3*i +: 3]  = bhw;
        req_rs1[32*i +: 32] = rs1;
        req_rs2[32*i +: 32] = rs2;
        req_imm[32*i +: 32] = imm;
    endtask

    task automatic wait_grant(output logic [1:0] g, output int gc);
        g  = '0;
        gc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_grant != 2'b00) begin g = req_grant; gc = cyc; break; end
        end
        if (gc < 0) timeout_fail("grant_wait");
    endtask

    task automatic wait_done(output logic [1:0] d, output logic e, output int dc, output int n_cs,
                             output logic [31:0] addr1, output logic [31:0] din1, output logic we1);
        d = '0; e = 0; dc = -1; n_cs = 0; addr1 = '0; din1 = '0; we1 = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) begin addr1 = ram_addr; din1 = ram_din; we1 = ram_we; end
            if (ram_cs) n_cs++;
            if (done != 2'b00) begin d = done; e = err; dc = cyc; break; end
        end
        if (dc < 0) timeout_fail("done_wait");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [1:0]  g, d;
        logic        e, we1, saw_done;
        int          gc, dc, n_cs;
        logic [31:0] addr1, din1;
        logic [1:0]  exp_seq [4];
        logic [1:0]  gs [4];
        int          gcs [4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single load from requester 0
        set_req(0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h4);
        req_valid = 2'b01;
        wait_grant(g, gc);
        check("load_grant", g, 2'b01);
        @(posedge clk); #2 req_valid = 2'b00;
        wait_done(d, e, dc, n_cs, addr1, din1, we1);
        check("load_addr", addr1, 32'h0000_0104);
        check("load_cs_cycles", n_cs, 2);
        check("load_latency", dc - gc, 3);
        check("load_done", d, 2'b01);
        check("load_rdata", rdata, 32'hCAFE_0104);

        // Store from requester 1
        @(posedge clk); #2;
        set_req(1, 1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 32'h10);
        req_valid = 2'b10;
        wait_grant(g, gc);
        check("store_grant", g, 2'b10);
        @(posedge clk); #2 req_valid = 2'b00;
        wait_done(d, e, dc, n_cs, addr1, din1, we1);
        check("store_we", we1, 1'b1);
        check("store_din", din1, 32'hDEAD_BEEF);
        check("store_cs_cycles", n_cs, 2);
        check("store_done", d, 2'b10);
        check("store_rdata_kept", rdata, 32'hCAFE_0104);

        // Fairness with both requesters held
        @(posedge clk); #2;
        set_req(0, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 32'h1);
        set_req(1, 1'b1, 3'b001, 32'h0000_0400, 32'h1234_5678, 32'h2);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(gs[k], gcs[k]);
            if (k == 3) begin @(posedge clk); #2 req_valid = 2'b00; end
        end
        for (int k = 0; k < 4; k++) begin
            check("fair_grant", gs[k], exp_seq[k]);
            if (k > 0) check("fair_spacing", gcs[k] - gcs[k-1], 4);
        end
        wait_done(d, e, dc, n_cs, addr1, din1, we1);
        check("fair_last_done", d, 2'b10);

        // 32-bit address wrap
        @(posedge clk); #2;
        set_req(0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h8);
        req_valid = 2'b01;
        wait_grant(g, gc);
        @(posedge clk); #2 req_valid = 2'b00;
        wait_done(d, e, dc, n_cs, addr1, din1, we1);
        check("wrap_addr", addr1, 32'h0000_0004);
        check("wrap_rdata", rdata, 32'hCAFE_0004);

        // Misaligned word access at 0x102
        @(posedge clk); #2;
        set_req(0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h2);
        req_valid = 2'b01;
        wait_grant(g, gc);
        @(posedge clk); #2 req_valid = 2'b00;
        wait_done(d, e, dc, n_cs, addr1, din1, we1);
        check("mis_done", d, 2'b01);
`ifdef MEM_ARB_MISALIGN_CHK_EN
        check("mis_cs_cycles", n_cs, 0);
        check("mis_latency", dc - gc, 1);
        check("mis_err", e, 1'b1);
        check("mis_rdata_kept", rdata, 32'hCAFE_0004);
`else
        check("mis_cs_cycles", n_cs, 2);
        check("mis_addr", addr1, 32'h0000_0102);
        check("mis_err", e, 1'b0);
        check("mis_rdata", rdata, 32'hCAFE_0102);
`endif

        // Reset in the first BUSY cycle of a requester-0 load
        @(posedge clk); #2;
        set_req(0, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0);
        req_valid = 2'b01;
        wait_grant(g, gc);
        @(posedge clk); #2 req_valid = 2'b00;
        check("busy_cs_before_rst", ram_cs, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_cs_drop", ram_cs, 1'b0);
        check("rst_rdata_clear", rdata, 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        set_req(1, 1'b1, 3'b010, 32'h0000_0600, 32'h5555_AAAA, 32'h0);
        req_valid = 2'b11;
        saw_done = 0;
        g = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done != 2'b00) saw_done = 1;
            if (req_grant != 2'b00) begin g = req_grant; break; end
        end
        check("rst_no_done", saw_done, 1'b0);
        check("rst_next_grant", g, 2'b01);
        @(posedge clk); #2 req_valid = 2'b00;
        wait_done(d, e, dc, n_cs, addr1, din1, we1);
        check("post_rst_done", d, 2'b01);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
